instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 25 ++
 rtl/instr_fetch_if.sv | 21 ++
 rtl/pc_next_logic.sv | 33 +++
 rtl/instr_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_fetch.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch state encoding and reset vector.
// Also holds the branch-offset helper used by the next-PC logic.
package mips_pkg;

    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] ADDI  = 6'h08;
    localparam logic [5:0] J     = 6'h02;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_ERR   = 2'b10
    } fetch_state_t;

    // Word offset of a branch: sign-extend the 16-bit immediate and scale to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: jump beats branch, branch beats sequential.
module pc_next_logic
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] pcplus4,
    output logic [31:0] pcnext
);

    logic [31:0] branch_s;
    logic [31:0] jtarget_s;
    logic [5:0]  unused_op_s;

    assign unused_op_s = instr[31:26];

    // Candidate targets and priority select; all sums wrap modulo 2^32.
    always_comb begin
        pcplus4   = pc + 32'd4;
        branch_s  = pcplus4 + branch_offset(instr[15:0]);
        jtarget_s = {pcplus4[31:28], instr[25:0], 2'b00};
        if (jump) begin
            pcnext = jtarget_s;
        end else if (pcsrc) begin
            pcnext = branch_s;
        end else begin
            pcnext = pcplus4;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetches one word per instruction, holds it in IR until the
// downstream asserts advance, then steps the PC. A memory that never answers parks it in ERR.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_if.master      imem,
    output logic [31:0]        instr,
    output logic [5:0]         op,
    output logic [5:0]         funct,
    output logic               instr_valid,
    input  logic               advance,
    input  logic               pcsrc,
    input  logic               jump,
    output logic [31:0]        pc,
    output logic [31:0]        pcplus4,
    output logic [31:0]        retired,
    output logic               fetch_err
);

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    fetch_state_t  state_r, state_s;
    logic          req_r, req_s;
    logic          valid_r, valid_s;
    logic          err_r, err_s;
    logic [WW-1:0] wait_r, wait_s;
    logic          load_ir_s, retire_s;
    logic [31:0]   ir_r, pc_r, retired_r, pcnext_s;

    pc_next_logic u_pc_next (
        .pc      (pc_r),
        .instr   (ir_r),
        .pcsrc   (pcsrc),
        .jump    (jump),
        .pcplus4 (pcplus4),
        .pcnext  (pcnext_s)
    );

    // State register with its registered handshake outputs and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            wait_r  <= '0;
        end else begin
            state_r <= state_s;
            req_r   <= req_s;
            valid_r <= valid_s;
            err_r   <= err_s;
            wait_r  <= wait_s;
        end
    end

    // Next state; ready only counts once the request is actually on the bus.
    always_comb begin
        state_s   = state_r;
        wait_s    = wait_r;
        err_s     = err_r;
        load_ir_s = 1'b0;
        retire_s  = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (!req_r) begin
                    state_s = S_FETCH;
                end else if (imem.imem_ready) begin
                    load_ir_s = 1'b1;
                    wait_s    = '0;
                    state_s   = S_EXEC;
                end else if (wait_r == WAIT_LAST) begin
                    err_s   = 1'b1;
                    state_s = S_ERR;
                end else begin
                    wait_s = wait_r + WW'(1);
                end
            end
            S_EXEC: begin
                if (advance) begin
                    retire_s = 1'b1;
                    state_s  = S_FETCH;
                end else begin
                    state_s = S_EXEC;
                end
            end
            S_ERR: begin
                state_s = S_ERR;
            end
            default: begin
                err_s   = 1'b1;
                state_s = S_ERR;
            end
        endcase
    end

    // Output decode of the upcoming state, registered alongside it.
    always_comb begin
        req_s   = 1'b0;
        valid_s = 1'b0;
        if (state_s == S_FETCH) begin
            req_s = 1'b1;
        end else if (state_s == S_EXEC) begin
            valid_s = 1'b1;
        end else begin
            req_s   = 1'b0;
            valid_s = 1'b0;
        end
    end

    // Datapath registers: IR, PC and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_r      <= 32'h0000_0000;
            pc_r      <= {RESET_PC[31:2], 2'b00};
            retired_r <= 32'h0000_0000;
        end else begin
            if (load_ir_s) begin
                ir_r <= imem.imem_rdata;
            end
            if (retire_s) begin
                pc_r      <= {pcnext_s[31:2], 2'b00};
                retired_r <= retired_r + 32'd1;
            end
        end
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = pc_r;
    assign instr          = ir_r;
    assign op             = ir_r[31:26];
    assign funct          = ir_r[5:0];
    assign instr_valid    = valid_r;
    assign pc             = pc_r;
    assign retired        = retired_r;
    assign fetch_err      = err_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run checked
// against an arithmetic next-PC / retire-count reference model.
module tb_instr_fetch;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset, advance, pcsrc, jump;
    logic [31:0] instr, pc, pcplus4, retired;
    logic [5:0]  op, funct;
    logic        instr_valid, fetch_err;

    instr_fetch_if imem_bus ();

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_bus),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .instr_valid (instr_valid),
        .advance     (advance),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .retired     (retired),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [5:0]  ops [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference next-PC, written directly from the architectural rules.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                             input bit br, input bit jp);
        logic [31:0]        seq;
        logic signed [15:0] imm;
        int                 off;
        seq = p + 32'd4;
        imm = w[15:0];
        off = imm;
        if (jp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        else if (br) return seq + 32'(off * 4);
        else return seq;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; advance = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h0;
        step(); step();
        reset = 1'b0;
        m_pc = RESET_PC_DEFAULT; m_ret = 32'd0;
        step();
    endtask

    // Memory answers after 'delay' idle cycles; controller inputs are noise meanwhile.
    task automatic do_fetch(input logic [31:0] w, input int delay);
        for (int i = 0; i < delay; i++) begin
            imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = $urandom;
            advance = 1'($urandom); pcsrc = 1'($urandom); jump = 1'($urandom);
            step();
        end
        imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = w;
        advance = 1'($urandom); pcsrc = 1'($urandom); jump = 1'($urandom);
        step();
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = $urandom;
        advance = 1'b0; pcsrc = 1'b0; jump = 1'b0;
    endtask

    task automatic do_exec(input logic [31:0] w, input bit br, input bit jp, input int hold);
        for (int i = 0; i < hold; i++) begin
            advance = 1'b0; pcsrc = 1'($urandom); jump = 1'($urandom);
            imem_bus.imem_rdata = $urandom;
            step();
        end
        advance = 1'b1; pcsrc = br; jump = jp;
        step();
        advance = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        m_pc  = ref_next(m_pc, w, br, jp);
        m_ret = m_ret + 32'd1;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        logic [31:0] w;
        w = {J, target[27:2]};
        do_fetch(w, 0);
        do_exec(w, 1'b0, 1'b1, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; advance = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h0;
        #2;
        total++; if (pc !== RESET_PC_DEFAULT) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC_DEFAULT); end
        total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired: got %h want 0", retired); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", fetch_err); end
        total++; if (instr !== 32'd0 || op !== 6'd0 || funct !== 6'd0) begin bad++; $display("FAIL reset_ir: got %h want 0", instr); end
        step(); step();
        reset = 1'b0;
        m_pc = RESET_PC_DEFAULT; m_ret = 32'd0;
        total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL release_req_low: got %b want 0", imem_bus.imem_req); end
        step();
        total++; if (imem_bus.imem_req !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", imem_bus.imem_req); end
        total++; if (imem_bus.imem_addr !== RESET_PC_DEFAULT) begin bad++; $display("FAIL first_addr: got %h want %h", imem_bus.imem_addr, RESET_PC_DEFAULT); end
    endtask

    task automatic test_add();
        do_fetch(32'h0000_0020, 0);
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", instr_valid); end
        total++; if (op !== 6'd0 || funct !== 6'd32) begin bad++; $display("FAIL add_decode: got op=%0d funct=%0d want op=0 funct=32", op, funct); end
        total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL add_req_exec: got %b want 0", imem_bus.imem_req); end
        do_exec(32'h0000_0020, 1'b0, 1'b0, 0);
        total++; if (pc !== 32'd4 || retired !== 32'd1) begin bad++; $display("FAIL add_advance: got pc=%h ret=%0d want pc=4 ret=1", pc, retired); end
        total++; if (instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1) begin bad++; $display("FAIL add_refetch: got valid=%b req=%b want 0/1", instr_valid, imem_bus.imem_req); end
    endtask

    task automatic test_beq();
        do_fetch(32'h0, 0); do_exec(32'h0, 1'b0, 1'b0, 0);
        do_fetch(32'h1000_0003, 1);
        total++; if (op !== BEQ || pcplus4 !== 32'd12) begin bad++; $display("FAIL beq_decode: got op=%h pcplus4=%h want %h/0000000c", op, pcplus4, BEQ); end
        do_exec(32'h1000_0003, 1'b1, 1'b0, 1);
        total++; if (pc !== 32'd24) begin bad++; $display("FAIL beq_taken: got %h want 00000018", pc); end
        do_reset();
        do_fetch(32'h0, 0); do_exec(32'h0, 1'b0, 1'b0, 0);
        do_fetch(32'h0, 0); do_exec(32'h0, 1'b0, 1'b0, 0);
        do_fetch(32'h1000_0003, 0); do_exec(32'h1000_0003, 1'b0, 1'b0, 0);
        total++; if (pc !== 32'd12) begin bad++; $display("FAIL beq_not_taken: got %h want 0000000c", pc); end
    endtask

    task automatic test_jump();
        goto_pc(32'h0000_0100);
        total++; if (pc !== 32'h100) begin bad++; $display("FAIL jump_setup: got %h want 00000100", pc); end
        do_fetch(32'h0800_0010, 0);
        do_exec(32'h0800_0010, 1'b1, 1'b1, 0);
        total++; if (pc !== 32'h40) begin bad++; $display("FAIL jump_priority: got %h want 00000040", pc); end
    endtask

    task automatic test_wait();
        logic [31:0] w;
        bit          ok;
        w  = 32'h2008_0005;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = $urandom;
            step();
            if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h40 || instr_valid !== 1'b0) ok = 1'b0;
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL wait_hold: got req=%b addr=%h valid=%b want 1/00000040/0", imem_bus.imem_req, imem_bus.imem_addr, instr_valid); end
        imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = w;
        step();
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = $urandom;
        total++; if (instr_valid !== 1'b1 || instr !== w) begin bad++; $display("FAIL wait_exec: got valid=%b instr=%h want 1/%h", instr_valid, instr, w); end
        do_exec(w, 1'b0, 1'b0, 2);
    endtask

    task automatic test_wrap();
        do_reset();
        do_fetch(32'h1000_FFFE, 0);
        do_exec(32'h1000_FFFE, 1'b1, 1'b0, 0);
        total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_branch_back: got %h want fffffffc", pc); end
        do_fetch(32'h0, 0);
        total++; if (pcplus4 !== 32'd0) begin bad++; $display("FAIL wrap_pcplus4: got %h want 0", pcplus4); end
        do_exec(32'h0, 1'b0, 1'b0, 0);
        total++; if (pc !== 32'd0 || imem_bus.imem_addr !== 32'd0) begin bad++; $display("FAIL wrap_pc: got %h want 0", pc); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        bit          br, jp;
        for (int n = 0; n < 60; n++) begin
            w  = {ops[$urandom_range(0, 5)], 26'($urandom)};
            br = 1'($urandom); jp = 1'($urandom_range(0, 3) == 0);
            do_fetch(w, $urandom_range(0, 5));
            total++; if (instr_valid !== 1'b1 || instr !== w || op !== w[31:26] || funct !== w[5:0]) begin bad++; $display("FAIL rnd_ir[%0d]: got instr=%h valid=%b want %h", n, instr, instr_valid, w); end
            total++; if (pc !== m_pc || pcplus4 !== m_pc + 32'd4) begin bad++; $display("FAIL rnd_exec_pc[%0d]: got %h/%h want %h", n, pc, pcplus4, m_pc); end
            do_exec(w, br, jp, $urandom_range(0, 3));
            total++; if (pc !== m_pc || imem_bus.imem_addr !== m_pc || retired !== m_ret) begin bad++; $display("FAIL rnd_next[%0d]: got pc=%h ret=%0d want pc=%h ret=%0d", n, pc, retired, m_pc, m_ret); end
        end
    endtask

    task automatic test_timeout();
        int n;
        bit seen, req_ok;
        do_reset();
        n = 0; seen = 1'b0; req_ok = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = $urandom;
            step();
            n++;
            if (fetch_err === 1'b1) seen = 1'b1;
            else if (imem_bus.imem_req !== 1'b1) req_ok = 1'b0;
        end
        total++; if (n != 16 || !seen) begin bad++; $display("FAIL timeout_cycles: got %0d want 16", n); end
        total++; if (req_ok !== 1'b1) begin bad++; $display("FAIL timeout_req_held: got dropped want held"); end
        total++; if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL err_idle: got req=%b valid=%b want 0/0", imem_bus.imem_req, instr_valid); end
        imem_bus.imem_ready = 1'b1; advance = 1'b1;
        step(); step(); step();
        imem_bus.imem_ready = 1'b0; advance = 1'b0;
        total++; if (fetch_err !== 1'b1 || instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL err_terminal: got err=%b valid=%b req=%b want 1/0/0", fetch_err, instr_valid, imem_bus.imem_req); end
        reset = 1'b1;
        #1;
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", fetch_err); end
        step();
        reset = 1'b0;
        step();
        total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RESET_PC_DEFAULT) begin bad++; $display("FAIL err_restart: got req=%b addr=%h want 1/%h", imem_bus.imem_req, imem_bus.imem_addr, RESET_PC_DEFAULT); end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_fetch(32'h0, 0); do_exec(32'h0, 1'b0, 1'b0, 0);
        end
        do_fetch(32'h1000_0003, 0); do_exec(32'h1000_0003, 1'b1, 1'b0, 0);
        do_fetch(32'h0000_0020, 0);
        total++; if (pc !== 32'h20 || retired !== 32'd5 || instr_valid !== 1'b1) begin bad++; $display("FAIL mid_setup: got pc=%h ret=%0d valid=%b want 20/5/1", pc, retired, instr_valid); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (pc !== 32'd0 || retired !== 32'd0 || instr_valid !== 1'b0 || op !== 6'd0) begin bad++; $display("FAIL mid_reset: got pc=%h ret=%0d valid=%b op=%h want 0/0/0/0", pc, retired, instr_valid, op); end
        imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        reset = 1'b0;
        step();
        imem_bus.imem_ready = 1'b0;
        total++; if (instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1 || instr !== 32'd0) begin bad++; $display("FAIL late_ready: got valid=%b req=%b instr=%h want 0/1/0", instr_valid, imem_bus.imem_req, instr); end
    endtask

    initial begin
        ops[0] = RTYPE; ops[1] = LW; ops[2] = SW; ops[3] = BEQ; ops[4] = ADDI; ops[5] = J;
        test_reset();
        test_add();
        test_beq();
        test_jump();
        test_wait();
        test_wrap();
        test_random();
        test_timeout();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
